fpga2cpu_dma_sched: RTL and testbench



---
 rtl/fpga2cpu_pkg.sv | 39 +++
 rtl/fpga2cpu_dma_sched_queue_state_rf.sv | 74 +++++++
 rtl/fpga2cpu_dma_sched.sv | 252 +++++++++++++++++++++++++
 tb/tb_fpga2cpu_dma_sched.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga2cpu_pkg.sv
// Shared types for the multi-queue FPGA-to-CPU DMA scheduler.
// Contents: the write data mover descriptor, the FSM states and the chunk-length helper.
package fpga2cpu_pkg;

    typedef struct packed {
        logic [7:0]  func_nb;
        logic [7:0]  desc_id;
        logic [1:0]  app_spec;
        logic [7:0]  reserved;
        logic        single_src;
        logic        immediate;
        logic [17:0] nb_dwords;
        logic [63:0] dst_addr;
        logic [63:0] saddr_data;
    } pcie_desc_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DATA,
        ST_TAIL
    } state_t;

    // A chunk stops at whichever comes first: end of request, length cap,
    // CPU ring wrap or FPGA ring wrap.
    function automatic logic [31:0] chunk_len(input logic [31:0] remaining,
                                              input logic [31:0] max_flits,
                                              input logic [31:0] ring_room,
                                              input logic [31:0] fpga_room);
        logic [31:0] len;
        len = remaining;
        if (max_flits < len) len = max_flits;
        if (ring_room < len) len = ring_room;
        if (fpga_room < len) len = fpga_room;
        return len;
    endfunction

endpackage

// File: rtl/fpga2cpu_dma_sched_queue_state_rf.sv
// Per-queue CPU ring state: kmem base, ring size, head and tail.
// A config write overrides a same-cycle tail write-back to the same queue.
module queue_state_rf #(
    parameter int NB_QUEUES = 4,
    parameter int QID_W     = 2,
    parameter int RB_AWIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 head_we,
    input  logic [QID_W-1:0]     head_queue,
    input  logic [RB_AWIDTH-1:0] head_value,
    input  logic                 cfg_we,
    input  logic [QID_W-1:0]     cfg_queue,
    input  logic [63:0]          cfg_kmem_addr,
    input  logic [RB_AWIDTH:0]   cfg_rb_size,
    input  logic                 tail_we,
    input  logic [QID_W-1:0]     tail_queue,
    input  logic [RB_AWIDTH-1:0] tail_value,
    input  logic [QID_W-1:0]     rd_queue,
    output logic [63:0]          rd_kmem,
    output logic [RB_AWIDTH:0]   rd_rb_size,
    output logic [RB_AWIDTH-1:0] rd_head,
    output logic [RB_AWIDTH-1:0] rd_tail,
    input  logic [QID_W-1:0]     peek_queue,
    output logic [RB_AWIDTH-1:0] peek_tail
);

    logic [63:0]          kmem_arr [NB_QUEUES];
    logic [RB_AWIDTH:0]   rb_size_arr [NB_QUEUES];
    logic [RB_AWIDTH-1:0] head_arr [NB_QUEUES];
    logic [RB_AWIDTH-1:0] tail_arr [NB_QUEUES];

    generate
        for (genvar gi = 0; gi < NB_QUEUES; gi++) begin : g_queue
            logic [63:0]          kmem_reg;
            logic [RB_AWIDTH:0]   rb_size_reg;
            logic [RB_AWIDTH-1:0] head_reg;
            logic [RB_AWIDTH-1:0] tail_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    kmem_reg    <= '0;
                    rb_size_reg <= '0;
                    head_reg    <= '0;
                    tail_reg    <= '0;
                end else begin
                    if (head_we && head_queue == QID_W'(gi))
                        head_reg <= head_value;
                    if (tail_we && tail_queue == QID_W'(gi))
                        tail_reg <= tail_value;
                    if (cfg_we && cfg_queue == QID_W'(gi)) begin
                        kmem_reg    <= cfg_kmem_addr;
                        rb_size_reg <= cfg_rb_size;
                        head_reg    <= '0;
                        tail_reg    <= '0;
                    end
                end
            end

            assign kmem_arr[gi]    = kmem_reg;
            assign rb_size_arr[gi] = rb_size_reg;
            assign head_arr[gi]    = head_reg;
            assign tail_arr[gi]    = tail_reg;
        end
    endgenerate

    assign rd_kmem    = kmem_arr[rd_queue];
    assign rd_rb_size = rb_size_arr[rd_queue];
    assign rd_head    = head_arr[rd_queue];
    assign rd_tail    = tail_arr[rd_queue];
    assign peek_tail  = tail_arr[peek_queue];

endmodule

// File: rtl/fpga2cpu_dma_sched.sv
// Multi-queue FPGA-to-CPU DMA scheduler: splits each request into write
// descriptors on CPU-ring wrap, FPGA-ring wrap and length cap, then writes the tail.
module fpga2cpu_dma_sched
    import fpga2cpu_pkg::*;
#(
    parameter int          NB_QUEUES      = 4,
    parameter int          QID_W          = $clog2(NB_QUEUES),
    parameter int          PDU_AWIDTH     = 12,
    parameter int          RB_AWIDTH      = 10,
    parameter int          MAX_DESC_FLITS = 64,
    parameter logic [31:0] EP_BASE_ADDR   = 32'h0004_0000,
    parameter int          RB_BRAM_OFFSET = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [QID_W-1:0]      req_queue,
    input  logic [PDU_AWIDTH-1:0] req_base,
    input  logic [PDU_AWIDTH-1:0] req_size,
    input  logic                  cfg_we,
    input  logic [QID_W-1:0]      cfg_queue,
    input  logic [63:0]           cfg_kmem_addr,
    input  logic [RB_AWIDTH:0]    cfg_rb_size,
    input  logic                  head_we,
    input  logic [QID_W-1:0]      head_queue,
    input  logic [RB_AWIDTH-1:0]  head_value,
    output logic                  desc_valid,
    input  logic                  desc_ready,
    output pcie_desc_t            desc_data,
    output logic                  done_valid,
    output logic [QID_W-1:0]      done_queue,
    output logic [RB_AWIDTH-1:0]  done_tail,
    output logic                  err_valid,
    input  logic [QID_W-1:0]      tail_rd_queue,
    output logic [RB_AWIDTH-1:0]  tail_rd_data
);

    localparam int LEN_W = PDU_AWIDTH + 1;

    state_t                state_reg;
    logic [QID_W-1:0]      cur_queue_reg;
    logic [PDU_AWIDTH-1:0] fpga_ptr_reg;
    logic [PDU_AWIDTH-1:0] remaining_reg;
    logic [63:0]           kmem_reg;
    logic [RB_AWIDTH:0]    rb_size_reg;
    logic [RB_AWIDTH-1:0]  cur_tail_reg;
    logic [LEN_W-1:0]      cur_len_reg;
    logic [7:0]            desc_id_reg;
    logic                  cfg_hit_reg;
    logic                  req_ready_reg;
    logic                  desc_valid_reg;
    pcie_desc_t            desc_data_reg;
    logic                  done_valid_reg;
    logic [QID_W-1:0]      done_queue_reg;
    logic [RB_AWIDTH-1:0]  done_tail_reg;
    logic                  err_valid_reg;

    logic [63:0]           rd_kmem;
    logic [RB_AWIDTH:0]    rd_rb_size;
    logic [RB_AWIDTH-1:0]  rd_head;
    logic [RB_AWIDTH-1:0]  rd_tail;
    logic                  tail_we;

    logic [31:0]           ring_last;
    logic [31:0]           tail_sum;
    logic [31:0]           free_space;
    logic [RB_AWIDTH-1:0]  tail_next;
    logic [PDU_AWIDTH-1:0] ptr_next;
    logic [PDU_AWIDTH-1:0] rem_next;
    logic [RB_AWIDTH-1:0]  calc_tail;
    logic [PDU_AWIDTH-1:0] calc_ptr;
    logic [PDU_AWIDTH-1:0] calc_rem;
    logic [7:0]            calc_id;
    logic [LEN_W-1:0]      calc_len;
    pcie_desc_t            data_desc;
    pcie_desc_t            tail_desc;

    queue_state_rf #(
        .NB_QUEUES (NB_QUEUES),
        .QID_W     (QID_W),
        .RB_AWIDTH (RB_AWIDTH)
    ) u_queue_state_rf (
        .clk           (clk),
        .rst_n         (rst_n),
        .head_we       (head_we),
        .head_queue    (head_queue),
        .head_value    (head_value),
        .cfg_we        (cfg_we),
        .cfg_queue     (cfg_queue),
        .cfg_kmem_addr (cfg_kmem_addr),
        .cfg_rb_size   (cfg_rb_size),
        .tail_we       (tail_we),
        .tail_queue    (cur_queue_reg),
        .tail_value    (cur_tail_reg),
        .rd_queue      (cur_queue_reg),
        .rd_kmem       (rd_kmem),
        .rd_rb_size    (rd_rb_size),
        .rd_head       (rd_head),
        .rd_tail       (rd_tail),
        .peek_queue    (tail_rd_queue),
        .peek_tail     (tail_rd_data)
    );

    // A config write that hit this queue mid-transfer suppresses the write-back.
    assign tail_we = (state_reg == ST_TAIL) && desc_ready && !cfg_hit_reg;

    always_comb begin
        ring_last = 32'(rb_size_reg) - 32'd1;
        tail_sum  = 32'(cur_tail_reg) + 32'(cur_len_reg);
        if (tail_sum >= ring_last)
            tail_sum = tail_sum - ring_last;
        tail_next = RB_AWIDTH'(tail_sum);
        ptr_next  = fpga_ptr_reg + PDU_AWIDTH'(cur_len_reg);
        rem_next  = remaining_reg - PDU_AWIDTH'(cur_len_reg);

        if (32'(cur_tail_reg) >= 32'(rd_head))
            free_space = ring_last - 32'(cur_tail_reg) + 32'(rd_head) - 32'd1;
        else
            free_space = 32'(rd_head) - 32'(cur_tail_reg) - 32'd1;
    end

    // Next descriptor is built from current pointers in CHECK and from the
    // post-handshake pointers in DATA, so desc_data is always registered.
    always_comb begin
        calc_tail = cur_tail_reg;
        calc_ptr  = fpga_ptr_reg;
        calc_rem  = remaining_reg;
        calc_id   = desc_id_reg;
        if (state_reg == ST_DATA) begin
            calc_tail = tail_next;
            calc_ptr  = ptr_next;
            calc_rem  = rem_next;
            calc_id   = desc_id_reg + 8'd1;
        end
        calc_len = LEN_W'(chunk_len(32'(calc_rem), 32'(MAX_DESC_FLITS),
                                    ring_last - 32'(calc_tail),
                                    (32'd1 << PDU_AWIDTH) - 32'(calc_ptr)));

        data_desc            = '0;
        data_desc.desc_id    = calc_id;
        data_desc.nb_dwords  = 18'({calc_len, 4'h0});
        data_desc.dst_addr   = kmem_reg + ((64'(calc_tail) + 64'd1) << 6);
        data_desc.saddr_data = 64'(EP_BASE_ADDR)
                             + ((64'(RB_BRAM_OFFSET) + 64'(calc_ptr)) << 6);

        tail_desc            = '0;
        tail_desc.desc_id    = calc_id;
        tail_desc.immediate  = 1'b1;
        tail_desc.nb_dwords  = 18'd1;
        tail_desc.dst_addr   = kmem_reg;
        tail_desc.saddr_data = 64'(calc_tail);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cur_queue_reg  <= '0;
            fpga_ptr_reg   <= '0;
            remaining_reg  <= '0;
            kmem_reg       <= '0;
            rb_size_reg    <= '0;
            cur_tail_reg   <= '0;
            cur_len_reg    <= '0;
            desc_id_reg    <= '0;
            cfg_hit_reg    <= 1'b0;
            req_ready_reg  <= 1'b0;
            desc_valid_reg <= 1'b0;
            desc_data_reg  <= '0;
            done_valid_reg <= 1'b0;
            done_queue_reg <= '0;
            done_tail_reg  <= '0;
            err_valid_reg  <= 1'b0;
        end else begin
            done_valid_reg <= 1'b0;
            err_valid_reg  <= 1'b0;
            if (cfg_we && cfg_queue == cur_queue_reg && state_reg != ST_IDLE)
                cfg_hit_reg <= 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (req_valid && req_ready_reg) begin
                        req_ready_reg <= 1'b0;
                        cur_queue_reg <= req_queue;
                        fpga_ptr_reg  <= req_base;
                        remaining_reg <= req_size;
                        cfg_hit_reg   <= 1'b0;
                        state_reg     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    kmem_reg     <= rd_kmem;
                    rb_size_reg  <= rd_rb_size;
                    cur_tail_reg <= rd_tail;
                    if (remaining_reg == '0 || 32'(remaining_reg) + 32'd2 > 32'(rd_rb_size)) begin
                        err_valid_reg <= 1'b1;
                        req_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end else begin
                        state_reg <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (free_space >= 32'(remaining_reg)) begin
                        desc_valid_reg <= 1'b1;
                        desc_data_reg  <= data_desc;
                        cur_len_reg    <= calc_len;
                        state_reg      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (desc_ready) begin
                        cur_tail_reg  <= tail_next;
                        fpga_ptr_reg  <= ptr_next;
                        remaining_reg <= rem_next;
                        desc_id_reg   <= desc_id_reg + 8'd1;
                        if (rem_next == '0) begin
                            desc_data_reg <= tail_desc;
                            state_reg     <= ST_TAIL;
                        end else begin
                            desc_data_reg <= data_desc;
                            cur_len_reg   <= calc_len;
                        end
                    end
                end
                ST_TAIL: begin
                    if (desc_ready) begin
                        desc_valid_reg <= 1'b0;
                        desc_data_reg  <= '0;
                        desc_id_reg    <= desc_id_reg + 8'd1;
                        done_valid_reg <= 1'b1;
                        done_queue_reg <= cur_queue_reg;
                        done_tail_reg  <= cur_tail_reg;
                        req_ready_reg  <= 1'b1;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign desc_valid = desc_valid_reg;
    assign desc_data  = desc_data_reg;
    assign done_valid = done_valid_reg;
    assign done_queue = done_queue_reg;
    assign done_tail  = done_tail_reg;
    assign err_valid  = err_valid_reg;

endmodule

// File: tb/tb_fpga2cpu_dma_sched.sv
// Scoreboard bench for fpga2cpu_dma_sched: a ring-index model predicts every
// descriptor, completion and error; a monitor process compares DUT output.
module tb_fpga2cpu_dma_sched;
    import fpga2cpu_pkg::*;

    localparam int NQ   = 4;
    localparam int QW   = 2;
    localparam int PW   = 12;
    localparam int RW   = 10;
    localparam int MAXF = 64;

    typedef struct {
        int q;
        int t;
    } done_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [QW-1:0] req_queue = '0;
    logic [PW-1:0] req_base = '0;
    logic [PW-1:0] req_size = '0;
    logic          cfg_we = 1'b0;
    logic [QW-1:0] cfg_queue = '0;
    logic [63:0]   cfg_kmem_addr = '0;
    logic [RW:0]   cfg_rb_size = '0;
    logic          head_we = 1'b0;
    logic [QW-1:0] head_queue = '0;
    logic [RW-1:0] head_value = '0;
    logic          desc_valid;
    logic          desc_ready = 1'b0;
    pcie_desc_t    desc_data;
    logic          done_valid;
    logic [QW-1:0] done_queue;
    logic [RW-1:0] done_tail;
    logic          err_valid;
    logic [QW-1:0] tail_rd_queue = '0;
    logic [RW-1:0] tail_rd_data;

    int checks = 0;
    int errors = 0;
    int ready_mode = 1;  // 0 random, 1 always ready, 2 never ready

    pcie_desc_t exp_desc[$];
    done_t      exp_done[$];
    int         exp_err = 0;

    longint m_kmem[NQ];
    int     m_rb[NQ];
    int     m_tail[NQ];
    int     m_id = 0;

    fpga2cpu_dma_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_queue     (req_queue),
        .req_base      (req_base),
        .req_size      (req_size),
        .cfg_we        (cfg_we),
        .cfg_queue     (cfg_queue),
        .cfg_kmem_addr (cfg_kmem_addr),
        .cfg_rb_size   (cfg_rb_size),
        .head_we       (head_we),
        .head_queue    (head_queue),
        .head_value    (head_value),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .desc_data     (desc_data),
        .done_valid    (done_valid),
        .done_queue    (done_queue),
        .done_tail     (done_tail),
        .err_valid     (err_valid),
        .tail_rd_queue (tail_rd_queue),
        .tail_rd_data  (tail_rd_data)
    );

    always #5 clk = ~clk;

    // desc_ready only moves 2 time units after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       desc_ready = ($urandom_range(0, 3) != 0);
                1:       desc_ready = 1'b1;
                default: desc_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares every handshake, completion and error against the scoreboard.
    initial begin
        pcie_desc_t held;
        pcie_desc_t e;
        done_t      d;
        bit         stall_prev;
        stall_prev = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 0;
            end else begin
                if (desc_valid) begin
                    if (stall_prev) begin
                        checks++;
                        if (desc_data !== held) begin
                            errors++;
                            $display("FAIL desc_stable actual=%h required=%h", desc_data, held);
                        end
                    end
                    if (desc_ready) begin
                        checks++;
                        if (exp_desc.size() == 0) begin
                            errors++;
                            $display("FAIL desc_unexpected actual=%h required=none", desc_data);
                        end else begin
                            e = exp_desc.pop_front();
                            if (desc_data !== e) begin
                                errors++;
                                $display("FAIL desc actual=%h required=%h", desc_data, e);
                            end else begin
                                $display("desc id=%0d imm=%0d dw=%0d dst=%h src=%h", desc_data.desc_id,
                                         desc_data.immediate, desc_data.nb_dwords,
                                         desc_data.dst_addr, desc_data.saddr_data);
                            end
                        end
                        stall_prev = 0;
                    end else begin
                        stall_prev = 1;
                        held = desc_data;
                    end
                end else begin
                    stall_prev = 0;
                end
                if (done_valid) begin
                    checks++;
                    if (exp_done.size() == 0) begin
                        errors++;
                        $display("FAIL done_unexpected actual=q%0d/t%0d required=none", done_queue, done_tail);
                    end else begin
                        d = exp_done.pop_front();
                        if (int'(done_queue) != d.q || int'(done_tail) != d.t) begin
                            errors++;
                            $display("FAIL done actual=q%0d/t%0d required=q%0d/t%0d",
                                     done_queue, done_tail, d.q, d.t);
                        end else begin
                            $display("done queue=%0d tail=%0d", done_queue, done_tail);
                        end
                    end
                end
                if (err_valid) begin
                    checks++;
                    if (exp_err == 0) begin
                        errors++;
                        $display("FAIL err_unexpected actual=1 required=0");
                    end else begin
                        exp_err--;
                        $display("err pulse");
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_outputs_zero(input string name);
        chk(name, 256'({req_ready, desc_valid, desc_data, done_valid, done_queue,
                        done_tail, err_valid, tail_rd_data}), 256'(0));
    endtask

    task automatic model_reset();
        for (int i = 0; i < NQ; i++) begin
            m_kmem[i] = 0;
            m_rb[i]   = 0;
            m_tail[i] = 0;
        end
        m_id = 0;
    endtask

    task automatic cfg_write(input int q, input longint kmem, input int rb);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_queue = QW'(q);
        cfg_kmem_addr = 64'(kmem);
        cfg_rb_size = (RW+1)'(rb);
        @(negedge clk);
        cfg_we = 1'b0;
        m_kmem[q] = kmem;
        m_rb[q]   = rb;
        m_tail[q] = 0;
    endtask

    task automatic head_write(input int q, input int h);
        @(negedge clk);
        head_we = 1'b1;
        head_queue = QW'(q);
        head_value = RW'(h);
        @(negedge clk);
        head_we = 1'b0;
    endtask

    // Reference model: walk 1-based ring slots idx in 1..rb-1 and FPGA flit addresses.
    task automatic do_req(input int q, input int base, input int size);
        pcie_desc_t d;
        int idx, ptr, rem, len, n;
        if (size == 0 || size > m_rb[q] - 2) begin
            exp_err++;
        end else begin
            idx = m_tail[q] + 1;
            ptr = base;
            rem = size;
            while (rem > 0) begin
                len = rem;
                if (len > MAXF) len = MAXF;
                if (len > m_rb[q] - idx) len = m_rb[q] - idx;
                if (len > 4096 - ptr) len = 4096 - ptr;
                d = '0;
                d.desc_id    = 8'(m_id);
                d.nb_dwords  = 18'(len * 16);
                d.dst_addr   = 64'(m_kmem[q] + 64 * idx);
                d.saddr_data = 64'(longint'('h40000) + ptr * 64);
                exp_desc.push_back(d);
                m_id = (m_id + 1) % 256;
                idx += len;
                if (idx == m_rb[q]) idx = 1;
                ptr = (ptr + len) % 4096;
                rem -= len;
            end
            d = '0;
            d.desc_id    = 8'(m_id);
            d.immediate  = 1'b1;
            d.nb_dwords  = 18'd1;
            d.dst_addr   = 64'(m_kmem[q]);
            d.saddr_data = 64'(idx - 1);
            exp_desc.push_back(d);
            m_id = (m_id + 1) % 256;
            exp_done.push_back('{q: q, t: idx - 1});
            m_tail[q] = idx - 1;
        end
        @(negedge clk);
        req_valid = 1'b1;
        req_queue = QW'(q);
        req_base  = PW'(base);
        req_size  = PW'(size);
        n = 0;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            errors++;
            $display("FAIL req_accept actual=timeout required=ready");
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_desc.size() != 0 || exp_done.size() != 0 || exp_err != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL %s actual=timeout(desc=%0d done=%0d err=%0d) required=drained",
                     name, exp_desc.size(), exp_done.size(), exp_err);
            exp_desc.delete();
            exp_done.delete();
            exp_err = 0;
        end
    endtask

    task automatic chk_tail(input int q);
        tail_rd_queue = QW'(q);
        #1;
        chk("tail_rd", 256'(tail_rd_data), 256'(m_tail[q]));
    endtask

    initial begin
        int q, size, n;
        model_reset();
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("req_ready_after_reset", 256'(req_ready), 256'(1));

        // Basic single descriptor, then tail write.
        cfg_write(0, 64'h1000, 64);
        do_req(0, 0, 8);
        wait_idle("basic");
        chk_tail(0);
        chk("basic_tail_const", 256'(tail_rd_data), 256'(8));

        // CPU ring wrap: fill to tail 12, consume, then 6 flits split 3+3.
        cfg_write(1, 64'h2000, 16);
        do_req(1, 100, 12);
        wait_idle("fill_q1");
        head_write(1, 12);
        do_req(1, 200, 6);
        wait_idle("ring_wrap");
        chk_tail(1);
        chk("ring_wrap_tail_const", 256'(tail_rd_data), 256'(3));

        // FPGA ring wrap.
        head_write(0, m_tail[0]);
        do_req(0, 4094, 4);
        wait_idle("fpga_wrap");
        chk_tail(0);

        // Length cap: 150 flits -> 64, 64, 22.
        cfg_write(3, 64'h0000_0001_0000_0000, 1024);
        do_req(3, 100, 150);
        wait_idle("max_len");
        chk_tail(3);

        // Stall on insufficient space, released by a head update.
        cfg_write(2, 64'h8000, 64);
        head_write(2, 2);
        do_req(2, 0, 8);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_no_desc", 256'(desc_valid), 256'(0));
        end
        head_write(2, 0);
        wait_idle("stall_release");
        chk_tail(2);

        // Illegal sizes.
        do_req(0, 0, 0);
        wait_idle("size_zero");
        do_req(1, 0, 15);
        wait_idle("size_too_big");

        // Back-pressure: descriptor must hold for 10 cycles.
        ready_mode = 2;
        head_write(0, m_tail[0]);
        do_req(0, 50, 3);
        n = 0;
        while (!desc_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("backpressure_valid", 256'(desc_valid), 256'(1));
        repeat (10) @(negedge clk);
        ready_mode = 1;
        wait_idle("backpressure");
        chk_tail(0);

        // Randomized traffic, includes desc_id wrap past 255.
        ready_mode = 0;
        for (int i = 0; i < 120; i++) begin
            q = int'($urandom_range(0, 3));
            head_write(q, m_tail[q]);
            if ($urandom_range(0, 9) == 0)
                size = ($urandom_range(0, 1) == 0) ? 0 : m_rb[q] - 1;
            else
                size = int'($urandom_range(1, (m_rb[q] - 2 < 300) ? m_rb[q] - 2 : 300));
            do_req(q, int'($urandom_range(0, 4095)), size);
            wait_idle("random");
            chk_tail(q);
        end

        // Reset in the middle of DATA.
        ready_mode = 2;
        head_write(0, m_tail[0]);
        do_req(0, 10, 8);
        n = 0;
        while (!desc_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reset_valid", 256'(desc_valid), 256'(1));
        exp_desc.delete();
        exp_done.delete();
        exp_err = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("mid_reset_outputs");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 1;
        chk_tail(0);

        // Clean restart: desc_id starts from 0 again.
        cfg_write(0, 64'h3000, 32);
        do_req(0, 7, 5);
        wait_idle("after_reset");
        chk_tail(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
